pwm_ctrl_multi: RTL and testbench
=================================

# pwm_ctrl_multi

Register-mapped, multi-channel PWM controller. It is the parametrised successor of the single-channel slave-register-plus-PWM top level. It provides NUM_CH independent PWM channels, each with its own period and duty registers. Each channel has double-buffered (shadow) registers that load only at period boundaries, so reprogramming never produces a glitched cycle. It sits between the host register bus and the motor driver gate inputs.

## Interface
- NUM_CH, 4: number of PWM channels. Must satisfy 1 ≤ NUM_CH ≤ DATA_WIDTH.
- DATA_WIDTH, 32: register bus data width.
- ADDR_WIDTH, 4: register bus address width. Must satisfy 2^ADDR_WIDTH ≥ 2 + 2·NUM_CH.
- CNT_WIDTH, 16: period/duty counter width. Must satisfy CNT_WIDTH ≤ DATA_WIDTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- writeValid  in  1  write strobe; one write per high cycle.
- writeAddress  in  ADDR_WIDTH  write register index.
- writeData  in  DATA_WIDTH  write data.
- writeResponse  out  1  one-cycle pulse, the cycle after each accepted writeValid.
- writeError  out  1  valid with writeResponse; 1 = unmapped address, write discarded.
- readAddress  in  ADDR_WIDTH  read register index, sampled every cycle.
- readData  out  DATA_WIDTH  registered read data.
- pwm  out  NUM_CH  registered PWM outputs, bit i = channel i.

## Operation
Register map:
- 0 CTRL (RW): bit i = enable for channel i. Upper bits are ignored on write and read as 0.
- 1 UPDATE (W1S): writing 1 to bit i sets pending[i]; writing 0 has no effect. Reads return pending.
- 2+2i PERIOD_i (RW): low CNT_WIDTH bits are stored; upper bits read as 0.
- 3+2i DUTY_i (RW): same width rule as PERIOD_i.
- Any other address: write discarded with writeError=1; read returns 0.

Each channel keeps active copies periodAct and dutyAct, plus a counter cnt, all CNT_WIDTH bits wide. PERIOD/DUTY writes never affect the output directly; only a shadow load does.

Channel state per edge:
- If en=0: cnt←0, pwm←0.
- If en=1 and periodAct=0: cnt←0, pwm←0.
- Otherwise: pwm←(cnt < dutyAct); cnt←(cnt = periodAct−1) ? 0 : cnt+1.
- dutyAct ≥ periodAct gives constant high; dutyAct=0 gives constant low.

Shadow load of channel i (periodAct←PERIOD_i, dutyAct←DUTY_i, cnt←0, pending[i]←0) happens on an edge where pending[i]=1 and one of the following holds:
- en=0, or
- periodAct=0, or
- cnt = periodAct−1 (the wrap edge).

Shadow load edge cases:
- The load uses register values as they are before that edge. A PERIOD/DUTY write on the same edge takes effect at the next load.
- An UPDATE write setting bit i on the same edge as a load of channel i leaves pending[i]=1. The set wins.
- Setting UPDATE again while pending is already set has no extra effect.

## Timing
- Reset (rstn=0 at an edge) clears all of the following:
  - CTRL, pending, PERIOD_i, DUTY_i, periodAct, dutyAct, cnt
  - pwm, writeResponse, writeError, readData

  All are 0 after that edge. Reset mid-period drops pwm low immediately, with no completion of the period.
- Write latency:
  - writeValid sampled at edge k updates the register at edge k.
  - writeResponse/writeError are high for the cycle after edge k.
  - Back-to-back writes are allowed, one per cycle.
- Read latency: readAddress at edge k → readData after edge k. A simultaneous write to the same address returns the old value.
- Enable timing:
  - A CTRL write at edge k enables the channel; the first counted cycle is edge k+1.
  - pwm is high after edge k+1 if dutyAct>0.
  - Disable at edge k: pwm is 0 after edge k+1.
- Period length is exactly periodAct clocks. High time is exactly min(dutyAct, periodAct) clocks.
- A shadow load at wrap edge k gives a new period starting at edge k+1 with no short or long cycle.

## Test plan
- Reset, then program PERIOD_0=10, DUTY_0=3, UPDATE=1, CTRL=1 → pwm[0] repeats 3 high / 7 low. Other channels stay 0 and writeResponse pulses once per write with writeError=0.
- Channel 0 running 10/3. Write DUTY_0=6 mid-period, then UPDATE=1 → current period still has 3 high. The next period, starting right after the wrap, has 6 high / 4 low. UPDATE reads 0 after the load.
- Set DUTY_1=20 with PERIOD_1=8 → pwm[1] constant high. Set DUTY_1=0 → constant low. Set PERIOD_1=0 → low, cnt held at 0.
- Program all NUM_CH channels with distinct period/duty values and enable all in one CTRL write (0xF) → each output matches its own ratio, with all channels starting on the same cycle.
- Write to address 15 → writeError=1, no register changes, and reading 15 returns 0. Write UPDATE on the exact wrap edge of a load → pending stays set and a second load occurs at the following wrap.
- Assert rstn=0 for 1 cycle mid-high phase → pwm=0 and all registers read 0. With no reprogramming, outputs stay low.

Source files
------------

// File: rtl/pwm_ctrl_multi_if.sv
// Host register bus for pwm_ctrl_multi: a write channel with a one-cycle response,
// and a read channel whose address is sampled every cycle.
interface pwm_ctrl_multi_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic                  writeValid;
   logic [ADDR_WIDTH-1:0] writeAddress;
   logic [DATA_WIDTH-1:0] writeData;
   logic                  writeResponse;
   logic                  writeError;
   logic [ADDR_WIDTH-1:0] readAddress;
   logic [DATA_WIDTH-1:0] readData;

   modport master (
      output writeValid,
      output writeAddress,
      output writeData,
      output readAddress,
      input  writeResponse,
      input  writeError,
      input  readData
   );

   modport slave (
      input  writeValid,
      input  writeAddress,
      input  writeData,
      input  readAddress,
      output writeResponse,
      output writeError,
      output readData
   );
endinterface

// File: rtl/pwm_ctrl_multi.sv
// Register-mapped multi-channel PWM controller. Each channel has shadow PERIOD/DUTY
// registers that only reach the counter at a period boundary, so outputs never glitch.
module pwm_ctrl_multi #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rstn,
   pwm_ctrl_multi_if.slave      bus,
   output logic [NUM_CH-1:0]    pwm
);

   localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

   logic [NUM_CH-1:0]     r_ctrl;
   logic [NUM_CH-1:0]     r_pending;
   logic [NUM_CH-1:0]     r_pwm;
   logic [CNT_WIDTH-1:0]  r_period     [NUM_CH];
   logic [CNT_WIDTH-1:0]  r_duty       [NUM_CH];
   logic [CNT_WIDTH-1:0]  r_period_act [NUM_CH];
   logic [CNT_WIDTH-1:0]  r_duty_act   [NUM_CH];
   logic [CNT_WIDTH-1:0]  r_cnt        [NUM_CH];
   logic                  r_wr_resp;
   logic                  r_wr_err;
   logic [DATA_WIDTH-1:0] r_rd_data;

   logic                  w_sel_ctrl;
   logic                  w_sel_upd;
   logic [NUM_CH-1:0]     w_sel_period;
   logic [NUM_CH-1:0]     w_sel_duty;
   logic                  w_addr_hit;
   logic [NUM_CH-1:0]     w_run;
   logic [NUM_CH-1:0]     w_wrap;
   logic [NUM_CH-1:0]     w_load;
   logic [NUM_CH-1:0]     w_upd_set;
   logic [CNT_WIDTH-1:0]  w_wr_cnt;
   logic [DATA_WIDTH-1:0] w_rd_mux;
   logic                  w_unused_wdata;

   assign w_wr_cnt       = bus.writeData[CNT_WIDTH-1:0];
   assign w_unused_wdata = ^bus.writeData;

   always_comb begin
      w_sel_ctrl   = (bus.writeAddress == ADDR_WIDTH'(0));
      w_sel_upd    = (bus.writeAddress == ADDR_WIDTH'(1));
      w_sel_period = '0;
      w_sel_duty   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_sel_period[i] = (bus.writeAddress == ADDR_WIDTH'(2 + 2*i));
         w_sel_duty[i]   = (bus.writeAddress == ADDR_WIDTH'(3 + 2*i));
      end
      w_addr_hit = w_sel_ctrl | w_sel_upd | (|w_sel_period) | (|w_sel_duty);
      w_upd_set  = (bus.writeValid && w_sel_upd) ? bus.writeData[NUM_CH-1:0] : '0;
   end

   always_comb begin
      w_rd_mux = '0;
      if (bus.readAddress == ADDR_WIDTH'(0)) begin
         w_rd_mux[NUM_CH-1:0] = r_ctrl;
      end else if (bus.readAddress == ADDR_WIDTH'(1)) begin
         w_rd_mux[NUM_CH-1:0] = r_pending;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.readAddress == ADDR_WIDTH'(2 + 2*i)) begin
            w_rd_mux[CNT_WIDTH-1:0] = r_period[i];
         end
         if (bus.readAddress == ADDR_WIDTH'(3 + 2*i)) begin
            w_rd_mux[CNT_WIDTH-1:0] = r_duty[i];
         end
      end
   end

   // A channel that is not running (disabled or zero period) can take its shadow
   // values immediately; a running one waits for its wrap edge.
   always_comb begin
      w_run  = '0;
      w_wrap = '0;
      w_load = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_run[i]  = r_ctrl[i] && (r_period_act[i] != '0);
         w_wrap[i] = w_run[i] && (r_cnt[i] == (r_period_act[i] - C_ONE));
         w_load[i] = r_pending[i] && (!w_run[i] || w_wrap[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ctrl    <= '0;
         r_pending <= '0;
         r_pwm     <= '0;
         r_wr_resp <= 1'b0;
         r_wr_err  <= 1'b0;
         r_rd_data <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_period[i]     <= '0;
            r_duty[i]       <= '0;
            r_period_act[i] <= '0;
            r_duty_act[i]   <= '0;
            r_cnt[i]        <= '0;
         end
      end else begin
         r_wr_resp <= bus.writeValid;
         r_wr_err  <= bus.writeValid && !w_addr_hit;
         r_rd_data <= w_rd_mux;

         if (bus.writeValid && w_sel_ctrl) begin
            r_ctrl <= bus.writeData[NUM_CH-1:0];
         end

         // Set after clear so an UPDATE landing on a load edge keeps the channel pending.
         r_pending <= (r_pending & ~w_load) | w_upd_set;

         for (int i = 0; i < NUM_CH; i++) begin
            if (bus.writeValid && w_sel_period[i]) begin
               r_period[i] <= w_wr_cnt;
            end
            if (bus.writeValid && w_sel_duty[i]) begin
               r_duty[i] <= w_wr_cnt;
            end

            if (w_run[i]) begin
               r_pwm[i] <= (r_cnt[i] < r_duty_act[i]);
               r_cnt[i] <= w_wrap[i] ? '0 : (r_cnt[i] + C_ONE);
            end else begin
               r_pwm[i] <= 1'b0;
               r_cnt[i] <= '0;
            end

            if (w_load[i]) begin
               r_period_act[i] <= r_period[i];
               r_duty_act[i]   <= r_duty[i];
               r_cnt[i]        <= '0;
            end
         end
      end
   end

   assign bus.writeResponse = r_wr_resp;
   assign bus.writeError    = r_wr_err;
   assign bus.readData      = r_rd_data;
   assign pwm               = r_pwm;

endmodule

// File: tb/tb_pwm_ctrl_multi.sv
// Directed bench for pwm_ctrl_multi: stimulus pushes expected responses into queues,
// a negedge monitor pops and compares whenever a response is due.
module tb_pwm_ctrl_multi;
   localparam int NUM_CH = 4;
   localparam int DW     = 32;
   localparam int AW     = 4;
   localparam int CW     = 16;

   logic              clk  = 1'b0;
   logic              rstn = 1'b0;
   logic [NUM_CH-1:0] pwm;

   pwm_ctrl_multi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   pwm_ctrl_multi #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .bus(bus),
      .pwm(pwm)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_err  = 0;
   int edge_n = 0;

   logic wr_req  = 1'b0, rd_req  = 1'b0, pwm_req = 1'b0;
   logic wr_vld  = 1'b0, rd_vld  = 1'b0, pwm_vld = 1'b0;

   logic              q_wr  [$];
   logic [DW-1:0]     q_rd  [$];
   logic [NUM_CH-1:0] q_pwm [$];

   logic              m_err;
   logic [DW-1:0]     m_data;
   logic [NUM_CH-1:0] m_pwm;

   // Marks the cycle after a request, when the DUT's registered response is due.
   always @(posedge clk) begin
      wr_vld  <= wr_req;
      rd_vld  <= rd_req;
      pwm_vld <= pwm_req;
   end

   always @(negedge clk) begin
      if (wr_vld || bus.writeResponse) begin
         n_vec++;
         if (bus.writeResponse !== wr_vld) begin
            n_err++;
            $display("FAIL wr_resp edge=%0d got %b want %b", edge_n, bus.writeResponse, wr_vld);
         end
      end
      if (wr_vld) begin
         n_vec++;
         if (q_wr.size() == 0) begin
            n_err++;
            $display("FAIL wr_queue edge=%0d got response want none queued", edge_n);
         end else begin
            m_err = q_wr.pop_front();
            if (bus.writeError !== m_err) begin
               n_err++;
               $display("FAIL wr_err edge=%0d got %b want %b", edge_n, bus.writeError, m_err);
            end
         end
      end
      if (rd_vld) begin
         n_vec++;
         if (q_rd.size() == 0) begin
            n_err++;
            $display("FAIL rd_queue edge=%0d got read want none queued", edge_n);
         end else begin
            m_data = q_rd.pop_front();
            if (bus.readData !== m_data) begin
               n_err++;
               $display("FAIL rd_data edge=%0d got %h want %h", edge_n, bus.readData, m_data);
            end
         end
      end
      if (pwm_vld) begin
         n_vec++;
         if (q_pwm.size() == 0) begin
            n_err++;
            $display("FAIL pwm_queue edge=%0d got sample want none queued", edge_n);
         end else begin
            m_pwm = q_pwm.pop_front();
            if (pwm !== m_pwm) begin
               n_err++;
               $display("FAIL pwm edge=%0d got %b want %b", edge_n, pwm, m_pwm);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog edge=%0d got no finish want finish", edge_n);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      edge_n++;
      #1;
   endtask

   task automatic wr(input int a, input int d, input int err);
      bus.writeValid   = 1'b1;
      bus.writeAddress = AW'(a);
      bus.writeData    = DW'(d);
      wr_req           = 1'b1;
      q_wr.push_back(err != 0);
      tick();
      bus.writeValid   = 1'b0;
      wr_req           = 1'b0;
   endtask

   task automatic rd(input int a, input int exp_d);
      bus.readAddress = AW'(a);
      rd_req          = 1'b1;
      q_rd.push_back(DW'(exp_d));
      tick();
      rd_req          = 1'b0;
   endtask

   task automatic step(input logic [NUM_CH-1:0] exp_p);
      pwm_req = 1'b1;
      q_pwm.push_back(exp_p);
      tick();
      pwm_req = 1'b0;
   endtask

   // Output after edge e of a channel whose period started at edge s.
   function automatic logic f(input int e, input int s, input int p, input int d);
      return ((e - s) % p) < d;
   endfunction

   initial begin
      logic [NUM_CH-1:0] ex;
      int s0, s0n, s1, s1n, e, w, sa, sb;

      bus.writeValid   = 1'b0;
      bus.writeAddress = '0;
      bus.writeData    = '0;
      bus.readAddress  = '0;
      rstn = 1'b0;
      repeat (3) tick();
      rstn   = 1'b1;
      edge_n = 0;

      step(4'b0000);
      rd(0, 0);
      rd(2, 0);
      rd(1, 0);

      // channel 0 at 10/3
      wr(2, 10, 0);
      wr(3, 3, 0);
      wr(1, 1, 0);
      wr(0, 1, 0);
      s0 = edge_n + 1;
      for (int k = 0; k < 20; k++) begin
         e = edge_n + 1;
         step({3'b000, f(e, s0, 10, 3)});
      end

      // duty change mid-period takes effect after the wrap
      wr(3, 6, 0);
      wr(1, 1, 0);
      s0n = s0 + ((edge_n - s0) / 10 + 1) * 10;
      for (int k = 0; k < 28; k++) begin
         e  = edge_n + 1;
         ex = {3'b000, (e < s0n) ? f(e, s0, 10, 3) : f(e, s0n, 10, 6)};
         if (k == 1)       rd(1, 1);
         else if (k == 10) rd(1, 0);
         else if (k == 12) rd(3, 6);
         else              step(ex);
      end
      s0 = s0n;

      // channel 1: duty above period, then zero duty, then zero period
      wr(4, 8, 0);
      wr(5, 20, 0);
      wr(1, 2, 0);
      wr(0, 3, 0);
      s1 = edge_n + 1;
      for (int k = 0; k < 10; k++) begin
         e = edge_n + 1;
         step({2'b00, 1'b1, f(e, s0, 10, 6)});
      end
      wr(5, 0, 0);
      wr(1, 2, 0);
      s1n = s1 + ((edge_n - s1) / 8 + 1) * 8;
      for (int k = 0; k < 12; k++) begin
         e = edge_n + 1;
         step({2'b00, (e < s1n), f(e, s0, 10, 6)});
      end
      wr(4, 0, 0);
      wr(1, 2, 0);
      for (int k = 0; k < 10; k++) begin
         e = edge_n + 1;
         step({2'b00, 1'b0, f(e, s0, 10, 6)});
      end
      wr(4, 4, 0);
      wr(5, 5, 0);
      wr(1, 2, 0);
      s1 = edge_n + 2;
      for (int k = 0; k < 6; k++) begin
         e = edge_n + 1;
         step({2'b00, (e >= s1), f(e, s0, 10, 6)});
      end

      // all channels, distinct ratios, common start
      wr(0, 0, 0);
      wr(2, 5, 0);
      wr(3, 2, 0);
      wr(4, 4, 0);
      wr(5, 1, 0);
      wr(6, 6, 0);
      wr(7, 3, 0);
      wr(8, 7, 0);
      wr(9, 5, 0);
      wr(1, 15, 0);
      wr(0, 15, 0);
      s0 = edge_n + 1;
      for (int k = 0; k < 30; k++) begin
         e = edge_n + 1;
         step({f(e, s0, 7, 5), f(e, s0, 6, 3), f(e, s0, 4, 1), f(e, s0, 5, 2)});
      end

      // unmapped write
      wr(15, 32'hFFFF_FFFF, 1);
      rd(15, 0);
      rd(0, 15);
      rd(2, 5);
      rd(1, 0);

      // UPDATE on the exact load edge keeps pending for a second load
      wr(3, 1, 0);
      wr(1, 1, 0);
      w = s0 + ((edge_n - s0) / 5) * 5 + 4;
      if (w <= edge_n) w = w + 5;
      while (edge_n + 1 < w) begin
         e = edge_n + 1;
         step({f(e, s0, 7, 5), f(e, s0, 6, 3), f(e, s0, 4, 1), f(e, s0, 5, 2)});
      end
      wr(1, 1, 0);
      sa = edge_n + 1;
      wr(3, 4, 0);
      sb = sa + 5;
      for (int k = 0; k < 15; k++) begin
         e  = edge_n + 1;
         ex = {f(e, s0, 7, 5), f(e, s0, 6, 3), f(e, s0, 4, 1),
               (e < sb) ? f(e, sa, 5, 1) : f(e, sb, 5, 4)};
         if (k == 0)      rd(1, 1);
         else if (k == 4) rd(1, 0);
         else             step(ex);
      end

      // reset during channel 0 high phase
      rstn = 1'b0;
      step(4'b0000);
      rstn = 1'b1;
      rd(0, 0);
      rd(1, 0);
      rd(2, 0);
      rd(3, 0);
      rd(9, 0);
      repeat (10) step(4'b0000);

      repeat (3) tick();
      if (q_wr.size() != 0 || q_rd.size() != 0 || q_pwm.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain got %0d/%0d/%0d pending want 0/0/0",
                  q_wr.size(), q_rd.size(), q_pwm.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
